// File: rtl/framebuffer_arbiter.sv
// Framebuffer RAM arbiter: VGA reads have priority, bounded CPU wait forces CPU forward progress.
// Optional macro FBARB_STALL_CNT_EN adds vga_stall_cnt, a saturating count of preempted VGA cycles.
module framebuffer_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W:0]   vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FBARB_STALL_CNT_EN
    ,
    output logic [15:0]       vga_stall_cnt
`endif
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

    logic [ADDR_W-1:0] last_vga_addr;
    logic [WAIT_W-1:0] wait_cnt;
    tag_t              tag_p1;
    logic              vga_pending;
    logic              vga_blocked;
    logic              vga_issue;
    logic              cpu_busy;
    logic              cpu_issue;

    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] cnt);
        return (cnt >= WAIT_W'(CPU_MAX_WAIT)) ? WAIT_W'(CPU_MAX_WAIT) : cnt + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A request stays busy from its issue through its ack cycle, so it is never issued twice.
    always_comb begin
        vga_pending = (vga_addr != last_vga_addr);
        vga_blocked = vga_pending && (wait_cnt >= WAIT_W'(CPU_MAX_WAIT));
        vga_issue   = vga_pending && !vga_blocked;
        cpu_busy    = (tag_p1 == TAG_CPU) || cpu_ack;
        cpu_issue   = !vga_issue && cpu_req && !cpu_busy;
    end

    // Issue stage: choose the source and register the RAM access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            last_vga_addr <= '1;
            wait_cnt      <= '0;
            tag_p1        <= TAG_NONE;
        end else begin
            mem_we <= 1'b0;
            tag_p1 <= TAG_NONE;
            if (vga_issue) begin
                mem_addr      <= vga_addr;
                last_vga_addr <= vga_addr;
                tag_p1        <= TAG_VGA;
            end else if (cpu_issue) begin
                mem_addr <= cpu_addr;
                mem_we   <= cpu_we;
                if (cpu_we) begin
                    mem_wdata <= cpu_wdata;
                end else begin
                    tag_p1 <= TAG_CPU;
                end
            end
            if (!cpu_req || cpu_issue) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_sat_inc(wait_cnt);
            end
        end
    end

    // Capture stage: route returning RAM data by tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= cpu_issue && cpu_we;
            if (tag_p1 == TAG_CPU) begin
                cpu_rdata <= mem_rdata;
                cpu_ack   <= 1'b1;
            end
            if (tag_p1 == TAG_VGA) begin
                vga_data[DATA_W-1:0] <= mem_rdata;
            end
            // A preempted fetch leaves the word stale, so its valid bit must drop.
            if (vga_blocked) begin
                vga_data[DATA_W] <= 1'b0;
            end else if (tag_p1 == TAG_VGA) begin
                vga_data[DATA_W] <= 1'b1;
            end
        end
    end

`ifdef FBARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_stall_cnt <= '0;
        end else if (vga_blocked && cpu_issue) begin
            vga_stall_cnt <= sat_inc16(vga_stall_cnt);
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter: directed latency/priority/hazard cases plus random traffic.
module tb_framebuffer_arbiter;

    localparam int ADDR_W       = 24;
    localparam int DATA_W       = 16;
    localparam int CPU_MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic [DATA_W:0]   vga_data;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef FBARB_STALL_CNT_EN
    logic [15:0]       vga_stall_cnt;
`endif

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] data;
    } cpu_exp_t;

    logic [DATA_W:0] vga_q[$];
    cpu_exp_t        cpu_q[$];
    int              n_checks = 0;
    int              n_fail = 0;

    logic [DATA_W-1:0] ram [0:1023];
    logic [DATA_W-1:0] mdl [0:1023];
    logic              init_ram = 1'b1;

    always #5 clk = ~clk;

    framebuffer_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_addr(vga_addr), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FBARB_STALL_CNT_EN
        , .vga_stall_cnt(vga_stall_cnt)
`endif
    );

    function automatic logic [DATA_W-1:0] init_val(input int a);
        if (a == 16) return 16'hBEEF;
        if (a == 48) return 16'hAAAA;
        return 16'(a * 40503 + 4660);
    endfunction

    // RAM model: read data follows the registered address within the cycle, writes land at the edge
    assign mem_rdata = ram[mem_addr[9:0]];
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
        end else if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int lat);
        cpu_exp_t e;
        e.we   = we;
        e.data = we ? '0 : mdl[a[9:0]];
        cpu_q.push_back(e);
        if (we) mdl[a[9:0]] = d;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (cpu_ack !== 1'b1 && lat < 40);
        if (cpu_ack !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_timeout: no cpu_ack after %0d cycles, expected one", lat);
        end
        cpu_req = 1'b0;
    endtask

    // Monitor: every cpu_ack and every fresh valid VGA word pops one expectation
    initial begin
        logic [DATA_W:0]   prev;
        logic [DATA_W-1:0] last_rd;
        logic [DATA_W:0]   ve;
        cpu_exp_t          ce;
        prev    = '0;
        last_rd = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b0) last_rd = '0;
            if (cpu_ack === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cpu_ack_unexpected: got ack with rdata %0h, expected no ack", cpu_rdata);
                end else begin
                    ce = cpu_q.pop_front();
                    if (ce.we) begin
                        check("cpu_wr_rdata_held", 32'(cpu_rdata), 32'(last_rd));
                    end else begin
                        check("cpu_rd_data", 32'(cpu_rdata), 32'(ce.data));
                        last_rd = ce.data;
                    end
                end
            end
            if (vga_data[DATA_W] === 1'b1 && (prev[DATA_W] !== 1'b1 || vga_data !== prev)) begin
                if (vga_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vga_unexpected: got %0h, expected no new word", vga_data);
                end else begin
                    ve = vga_q.pop_front();
                    check("vga_data", 32'(vga_data), 32'(ve));
                end
            end
            prev = vga_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [ADDR_W-1:0] cur;
        for (int i = 0; i < 1024; i++) mdl[i] = init_val(i);

        // Reset held with active stimulus
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 24'h5;
        cpu_wdata = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            vga_addr = 24'(i * 3 + 1);
            tick();
            init_ram = 1'b0;
            check("rst_vga_data", 32'(vga_data), 32'h0);
            check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
            check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
            check("rst_mem_we", 32'(mem_we), 32'h0);
            check("rst_mem_addr", 32'(mem_addr), 32'h0);
            check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        end
`ifdef FBARB_STALL_CNT_EN
        check("rst_stall_cnt", 32'(vga_stall_cnt), 32'h0);
`endif

        // VGA read of 0x10
        rst_n = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        vga_addr = 24'h10;
        vga_q.push_back({1'b1, mdl[10'h10]});
        tick();
        check("vga_issue_addr", 32'(mem_addr), 32'h10);
        check("vga_not_yet", 32'(vga_data), 32'h0);
        tick();
        check("vga_lat2", 32'(vga_data), 32'h1BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("vga_stable_data", 32'(vga_data), 32'h1BEEF);
            check("vga_stable_we", 32'(mem_we), 32'h0);
        end

        // CPU write then read of 0x20
        cpu_op(1'b1, 24'h20, 16'h1234, lat);
        check("wr_lat", 32'(lat), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h20);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        check("wr_we_pulse", 32'(mem_we), 32'h0);
        check("wr_ack_pulse", 32'(cpu_ack), 32'h0);
        cpu_op(1'b0, 24'h20, 16'h0, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", 32'(cpu_rdata), 32'h1234);
        tick();
        check("rd_ack_pulse", 32'(cpu_ack), 32'h0);
        check("rd_data_held", 32'(cpu_rdata), 32'h1234);

        // Priority: VGA address moves every cycle while a CPU read waits
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 24'h40;
        cpu_q.push_back('{we: 1'b0, data: mdl[10'h40]});
        for (int i = 0; i <= 8; i++) begin
            vga_addr = 24'h200 + 24'(i);
            if (i < 7) vga_q.push_back({1'b1, mdl[10'h200 + 10'(i)]});
            tick();
            check("prio_issue_addr", 32'(mem_addr), (i < 8) ? 32'h200 + 32'(i) : 32'h40);
        end
        check("prio_valid_clear", 32'(vga_data[DATA_W]), 32'h0);
`ifdef FBARB_STALL_CNT_EN
        check("prio_stall_cnt", 32'(vga_stall_cnt), 32'h1);
`endif
        vga_q.push_back({1'b1, mdl[10'h208]});
        tick();
        check("prio_cpu_ack", 32'(cpu_ack), 32'h1);
        check("prio_reissue_addr", 32'(mem_addr), 32'h208);
        cpu_req = 1'b0;
        tick();
        check("prio_skipped_served", 32'(vga_data), 32'({1'b1, mdl[10'h208]}));

        // Same-cycle hazard on 0x30: VGA issued first sees old data
        vga_addr = 24'h30;
        vga_q.push_back({1'b1, mdl[10'h30]});
        cpu_op(1'b1, 24'h30, 16'h5555, lat);
        check("haz_wr_lat", 32'(lat), 32'd2);
        check("haz_vga_old", 32'(vga_data), 32'h1AAAA);
        tick();
        vga_addr = 24'h31;
        vga_q.push_back({1'b1, mdl[10'h31]});
        repeat (3) tick();
        vga_addr = 24'h30;
        vga_q.push_back({1'b1, mdl[10'h30]});
        repeat (3) tick();
        check("haz_vga_new", 32'(vga_data), 32'h15555);

        // Reset the cycle after a CPU read issue
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 24'h40;
        tick();
        check("rstmid_issue", 32'(mem_addr), 32'h40);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        tick();
        check("rstmid_no_ack", 32'(cpu_ack), 32'h0);
        check("rstmid_vga", 32'(vga_data), 32'h0);
        check("rstmid_rdata", 32'(cpu_rdata), 32'h0);
        check("rstmid_addr", 32'(mem_addr), 32'h0);
        tick();
        check("rstmid_no_ack2", 32'(cpu_ack), 32'h0);
`ifdef FBARB_STALL_CNT_EN
        check("rstmid_stall_cnt", 32'(vga_stall_cnt), 32'h0);
`endif
        vga_addr = 24'h50;
        vga_q.push_back({1'b1, mdl[10'h50]});
        rst_n = 1'b1;
        tick();
        check("rstmid_no_ack3", 32'(cpu_ack), 32'h0);
        tick();
        check("rstmid_vga_after", 32'(vga_data), 32'({1'b1, mdl[10'h50]}));

        // Random traffic: VGA scans 0x300-0x3FF, CPU works in 0x100-0x1FF
        cur = vga_addr;
        fork
            begin
                logic [ADDR_W-1:0] a;
                repeat (30) begin
                    do a = 24'h300 + 24'($urandom_range(0, 255)); while (a == cur);
                    cur = a;
                    vga_addr = a;
                    vga_q.push_back({1'b1, mdl[a[9:0]]});
                    repeat ($urandom_range(2, 5)) tick();
                end
            end
            begin
                int l;
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) tick();
                    cpu_op(1'($urandom_range(0, 1)), 24'h100 + 24'($urandom_range(0, 255)),
                           16'($urandom), l);
                    check("cpu_bounded_wait", 32'(l <= CPU_MAX_WAIT + 2), 32'h1);
                end
            end
        join

        for (int i = 0; i < 30 && (vga_q.size() != 0 || cpu_q.size() != 0); i++) tick();
        check("vga_q_drained", 32'(vga_q.size()), 32'h0);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
